// File: rtl/cr_ob_split_pkg.sv
// Shared tuser encodings, default type bytes and enums for the outbound frame splitter.
package cr_ob_split_pkg;

    localparam logic [7:0] TUSER_MID = 8'h00;
    localparam logic [7:0] TUSER_SOT = 8'h01;
    localparam logic [7:0] TUSER_EOT = 8'h02;
    localparam logic [7:0] TUSER_SOE = 8'h03;

    localparam logic [7:0] CQE_TYPE_DFLT   = 8'h09;
    localparam logic [7:0] STATS_TYPE_DFLT = 8'h08;

    typedef enum logic [1:0] {FT_DATA, FT_CQE, FT_STATS} frame_type_e;

    typedef enum logic [1:0] {ST_IDLE, ST_IN_DATA, ST_IN_CQE, ST_IN_STATS} split_state_e;

    function automatic frame_type_e state_type(input split_state_e s);
        case (s)
            ST_IN_CQE:   return FT_CQE;
            ST_IN_STATS: return FT_STATS;
            default:     return FT_DATA;
        endcase
    endfunction

    function automatic split_state_e type_state(input frame_type_e t);
        case (t)
            FT_CQE:   return ST_IN_CQE;
            FT_STATS: return ST_IN_STATS;
            default:  return ST_IN_DATA;
        endcase
    endfunction

endpackage

// File: rtl/cr_ob_split_skid.sv
// Two-entry skid buffer with a registered ready; ready drops only when both entries are occupied.
module cr_ob_split_skid #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic [W-1:0] r_mem0;
    logic [W-1:0] r_mem1;
    logic [1:0]   r_count;
    logic         r_ready;
    logic [1:0]   w_count_nxt;
    logic         w_push;
    logic         w_pop;

    assign w_push      = i_valid && r_ready;
    assign w_pop       = i_ready && (r_count != 2'd0);
    assign w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);

    assign o_ready = r_ready;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem0;

    // r_mem0 is always the head; r_mem1 only fills while the head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem0  <= '0;
            r_mem1  <= '0;
            r_count <= 2'd0;
            r_ready <= 1'b1;
        end else begin
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != 2'd2);
            if (w_pop) begin
                r_mem0 <= (r_count == 2'd2) ? r_mem1 : i_data;
            end else if (w_push && (r_count == 2'd0)) begin
                r_mem0 <= i_data;
            end
            if (w_push && !w_pop && (r_count == 2'd1)) begin
                r_mem1 <= i_data;
            end
        end
    end

endmodule

// File: rtl/cr_ob_frame_splitter.sv
// Routes outbound AXI-stream frames to a CQE stream or a data stream by the SoT type byte.
// Build option CR_OB_SPLIT_STATS_DROP_EN: swallow STATS frames instead of forwarding them on dat_*.
//
// state       | meaning
// ST_IDLE     | between frames, expecting an SoT beat
// ST_IN_DATA  | inside a data frame, beats go to dat_*
// ST_IN_CQE   | inside a completion frame, beats go to cqe_*
// ST_IN_STATS | inside a stats frame, beats go to dat_* (or are dropped)
module cr_ob_frame_splitter
    import cr_ob_split_pkg::*;
#(
    parameter int unsigned DW         = 64,
    parameter int unsigned SW         = 8,
    parameter int unsigned UW         = 8,
    parameter int unsigned IW         = 1,
    parameter logic [7:0]  CQE_TYPE   = CQE_TYPE_DFLT,
    parameter logic [7:0]  STATS_TYPE = STATS_TYPE_DFLT,
    parameter int unsigned CW         = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_tvalid,
    output logic          in_tready,
    input  logic [DW-1:0] in_tdata,
    input  logic [SW-1:0] in_tstrb,
    input  logic [UW-1:0] in_tuser,
    input  logic [IW-1:0] in_tid,
    input  logic          in_tlast,
    output logic          dat_tvalid,
    input  logic          dat_tready,
    output logic [DW-1:0] dat_tdata,
    output logic [SW-1:0] dat_tstrb,
    output logic [UW-1:0] dat_tuser,
    output logic [IW-1:0] dat_tid,
    output logic          cqe_tvalid,
    input  logic          cqe_tready,
    output logic [DW-1:0] cqe_tdata,
    output logic [SW-1:0] cqe_tstrb,
    output logic          cqe_tlast,
    output logic          err_framing,
    output logic          err_tlast,
    output logic [7:0]    err_cnt,
    output logic [CW-1:0] cnt_data,
    output logic [CW-1:0] cnt_cqe,
    output logic [CW-1:0] cnt_stats,
    output logic          idle
);

    localparam int unsigned PW = DW + SW + UW + IW + 1;

    logic [PW-1:0] w_skid_in;
    logic [PW-1:0] w_head;
    logic          w_head_valid;
    logic          w_pop;
    logic [DW-1:0] w_h_data;
    logic [SW-1:0] w_h_strb;
    logic [UW-1:0] w_h_user;
    logic [IW-1:0] w_h_id;
    logic          w_h_last;
    logic          w_sot;
    logic          w_eot;

    split_state_e  r_state;
    split_state_e  w_state_nxt;
    frame_type_e   w_type;
    logic          w_frm_err;
    logic          w_tl_err;
    logic          w_drop;
    logic          w_done;
    logic          w_to_dat;
    logic          w_to_cqe;
    logic [8:0]    w_err_sum;

    logic          r_dat_valid;
    logic [DW-1:0] r_dat_data;
    logic [SW-1:0] r_dat_strb;
    logic [UW-1:0] r_dat_user;
    logic [IW-1:0] r_dat_id;
    logic          r_cqe_valid;
    logic [DW-1:0] r_cqe_data;
    logic [SW-1:0] r_cqe_strb;
    logic          r_cqe_last;
    logic          r_err_framing;
    logic          r_err_tlast;
    logic [7:0]    r_err_cnt;
    logic [CW-1:0] r_cnt_data;
    logic [CW-1:0] r_cnt_cqe;
    logic [CW-1:0] r_cnt_stats;

    assign w_skid_in = {in_tlast, in_tid, in_tuser, in_tstrb, in_tdata};

    cr_ob_split_skid #(.W(PW)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (in_tvalid),
        .o_ready (in_tready),
        .i_data  (w_skid_in),
        .o_valid (w_head_valid),
        .i_ready (w_pop),
        .o_data  (w_head)
    );

    assign w_h_data = w_head[DW-1:0];
    assign w_h_strb = w_head[DW +: SW];
    assign w_h_user = w_head[DW+SW +: UW];
    assign w_h_id   = w_head[DW+SW+UW +: IW];
    assign w_h_last = w_head[PW-1];
    assign w_sot    = (w_h_user == UW'(TUSER_SOT)) || (w_h_user == UW'(TUSER_SOE));
    assign w_eot    = (w_h_user == UW'(TUSER_EOT)) || (w_h_user == UW'(TUSER_SOE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_type      = state_type(r_state);
        w_frm_err   = 1'b0;
        w_drop      = 1'b0;
        w_done      = 1'b0;
        if (w_sot) begin
            // An SoT always wins: it re-types and restarts, abandoning any open frame.
            w_frm_err = (r_state != ST_IDLE);
            if (w_h_data[7:0] == CQE_TYPE) begin
                w_type = FT_CQE;
            end else if (w_h_data[7:0] == STATS_TYPE) begin
                w_type = FT_STATS;
            end else begin
                w_type = FT_DATA;
            end
            w_done      = w_eot;
            w_state_nxt = w_eot ? ST_IDLE : type_state(w_type);
        end else if (r_state == ST_IDLE) begin
            w_frm_err = 1'b1;
            w_drop    = 1'b1;
        end else if (w_eot) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
        end
`ifdef CR_OB_SPLIT_STATS_DROP_EN
        if (w_type == FT_STATS) begin
            w_drop = 1'b1;
        end
`endif
        w_to_cqe = !w_drop && (w_type == FT_CQE);
        w_to_dat = !w_drop && (w_type != FT_CQE);
        w_pop    = w_head_valid &&
                   (w_drop ||
                    (w_to_cqe && (!r_cqe_valid || cqe_tready)) ||
                    (w_to_dat && (!r_dat_valid || dat_tready)));
        w_tl_err = (w_h_last != (w_eot && (w_type == FT_CQE)));
        if (!w_pop) begin
            w_state_nxt = r_state;
        end
    end

    assign w_err_sum = {1'b0, r_err_cnt} + 9'(w_pop && w_frm_err) + 9'(w_pop && w_tl_err);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dat_valid   <= 1'b0;
            r_dat_data    <= '0;
            r_dat_strb    <= '0;
            r_dat_user    <= '0;
            r_dat_id      <= '0;
            r_cqe_valid   <= 1'b0;
            r_cqe_data    <= '0;
            r_cqe_strb    <= '0;
            r_cqe_last    <= 1'b0;
            r_err_framing <= 1'b0;
            r_err_tlast   <= 1'b0;
            r_err_cnt     <= 8'd0;
            r_cnt_data    <= '0;
            r_cnt_cqe     <= '0;
            r_cnt_stats   <= '0;
        end else begin
            if (w_pop && w_to_dat) begin
                r_dat_valid <= 1'b1;
                r_dat_data  <= w_h_data;
                r_dat_strb  <= w_h_strb;
                r_dat_user  <= w_h_user;
                r_dat_id    <= w_h_id;
            end else if (dat_tready) begin
                r_dat_valid <= 1'b0;
            end
            if (w_pop && w_to_cqe) begin
                r_cqe_valid <= 1'b1;
                r_cqe_data  <= w_h_data;
                r_cqe_strb  <= w_h_strb;
                r_cqe_last  <= w_eot;
            end else if (cqe_tready) begin
                r_cqe_valid <= 1'b0;
            end
            r_err_framing <= w_pop && w_frm_err;
            r_err_tlast   <= w_pop && w_tl_err;
            r_err_cnt     <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
            if (w_pop && w_done) begin
                case (w_type)
                    FT_CQE:   r_cnt_cqe   <= r_cnt_cqe + CW'(1);
                    FT_STATS: r_cnt_stats <= r_cnt_stats + CW'(1);
                    default:  r_cnt_data  <= r_cnt_data + CW'(1);
                endcase
            end
        end
    end

    assign dat_tvalid  = r_dat_valid;
    assign dat_tdata   = r_dat_data;
    assign dat_tstrb   = r_dat_strb;
    assign dat_tuser   = r_dat_user;
    assign dat_tid     = r_dat_id;
    assign cqe_tvalid  = r_cqe_valid;
    assign cqe_tdata   = r_cqe_data;
    assign cqe_tstrb   = r_cqe_strb;
    assign cqe_tlast   = r_cqe_last;
    assign err_framing = r_err_framing;
    assign err_tlast   = r_err_tlast;
    assign err_cnt     = r_err_cnt;
    assign cnt_data    = r_cnt_data;
    assign cnt_cqe     = r_cnt_cqe;
    assign cnt_stats   = r_cnt_stats;
    assign idle        = (r_state == ST_IDLE) && !w_head_valid && !r_dat_valid && !r_cqe_valid;

endmodule

// File: tb/tb_cr_ob_frame_splitter.sv
// Scoreboard bench for cr_ob_frame_splitter: directed frames, queued expectations, output monitors.
module tb_cr_ob_frame_splitter;

    localparam int DW = 64;
    localparam int SW = 8;
    localparam int UW = 8;
    localparam int IW = 1;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_tvalid = 1'b0;
    logic          in_tready;
    logic [DW-1:0] in_tdata = '0;
    logic [SW-1:0] in_tstrb = '0;
    logic [UW-1:0] in_tuser = '0;
    logic [IW-1:0] in_tid = '0;
    logic          in_tlast = 1'b0;
    logic          dat_tvalid;
    logic          dat_tready = 1'b1;
    logic [DW-1:0] dat_tdata;
    logic [SW-1:0] dat_tstrb;
    logic [UW-1:0] dat_tuser;
    logic [IW-1:0] dat_tid;
    logic          cqe_tvalid;
    logic          cqe_tready = 1'b1;
    logic [DW-1:0] cqe_tdata;
    logic [SW-1:0] cqe_tstrb;
    logic          cqe_tlast;
    logic          err_framing;
    logic          err_tlast;
    logic [7:0]    err_cnt;
    logic [CW-1:0] cnt_data;
    logic [CW-1:0] cnt_cqe;
    logic [CW-1:0] cnt_stats;
    logic          idle;

    cr_ob_frame_splitter dut (
        .clk(clk), .rst_n(rst_n),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
        .in_tstrb(in_tstrb), .in_tuser(in_tuser), .in_tid(in_tid), .in_tlast(in_tlast),
        .dat_tvalid(dat_tvalid), .dat_tready(dat_tready), .dat_tdata(dat_tdata),
        .dat_tstrb(dat_tstrb), .dat_tuser(dat_tuser), .dat_tid(dat_tid),
        .cqe_tvalid(cqe_tvalid), .cqe_tready(cqe_tready), .cqe_tdata(cqe_tdata),
        .cqe_tstrb(cqe_tstrb), .cqe_tlast(cqe_tlast),
        .err_framing(err_framing), .err_tlast(err_tlast), .err_cnt(err_cnt),
        .cnt_data(cnt_data), .cnt_cqe(cnt_cqe), .cnt_stats(cnt_stats), .idle(idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_fr = 0;
    int n_tl = 0;
    int e_fr = 0;
    int e_tl = 0;
    int e_err = 0;
    int e_data = 0;
    int e_cqe = 0;
    int e_stats = 0;

    logic [DW+SW+UW+IW-1:0] q_dat[$];
    logic [DW+SW:0]         q_cqe[$];
    logic [DW+SW+UW+IW-1:0] dat_held;
    logic                   dat_stall = 1'b0;
    logic [5:0]             rdy_pat = 6'b101001;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void exp_dat(input logic [63:0] d, input logic [7:0] u,
                                    input logic [7:0] s = 8'hFF, input logic id = 1'b0);
        q_dat.push_back({d, s, u, id});
    endfunction

    function automatic void exp_cqe(input logic [63:0] d, input logic l, input logic [7:0] s = 8'hFF);
        q_cqe.push_back({d, s, l});
    endfunction

    // Called at a negedge; returns at the negedge after the beat transferred.
    task automatic send(input logic [63:0] d, input logic [7:0] u, input logic l,
                        input logic [7:0] s = 8'hFF, input logic id = 1'b0);
        int n = 0;
        in_tvalid = 1'b1;
        in_tdata  = d;
        in_tuser  = u;
        in_tlast  = l;
        in_tstrb  = s;
        in_tid    = id;
        while (!in_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", in_tready, 1'b1);
        @(negedge clk);
        in_tvalid = 1'b0;
    endtask

    task automatic set_dat_rdy(input logic v);
        @(posedge clk);
        #1 dat_tready = v;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (!(idle && q_dat.size() == 0 && q_cqe.size() == 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_idle", idle, 1'b1);
        @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_cnt_data"}, cnt_data, e_data[CW-1:0]);
        chk({tag, "_cnt_cqe"}, cnt_cqe, e_cqe[CW-1:0]);
        chk({tag, "_cnt_stats"}, cnt_stats, e_stats[CW-1:0]);
        chk({tag, "_err_cnt"}, err_cnt, e_err[7:0]);
        chk({tag, "_framing_pulses"}, n_fr, e_fr);
        chk({tag, "_tlast_pulses"}, n_tl, e_tl);
        chk({tag, "_dat_q_left"}, q_dat.size(), 0);
        chk({tag, "_cqe_q_left"}, q_cqe.size(), 0);
    endtask

    always @(negedge clk) begin
        if (err_framing) n_fr++;
        if (err_tlast) n_tl++;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            dat_stall = 1'b0;
        end else begin
            if (dat_stall) begin
                chk("dat_hold_valid", dat_tvalid, 1'b1);
                chk("dat_hold_payload", {dat_tdata, dat_tstrb, dat_tuser, dat_tid}, dat_held);
            end
            if (dat_tvalid && dat_tready) begin
                if (q_dat.size() == 0) begin
                    chk("dat_unexpected_beat", {dat_tdata, dat_tstrb, dat_tuser, dat_tid}, 0);
                end else begin
                    chk("dat_beat", {dat_tdata, dat_tstrb, dat_tuser, dat_tid}, q_dat.pop_front());
                end
            end
            dat_stall = dat_tvalid && !dat_tready;
            dat_held  = {dat_tdata, dat_tstrb, dat_tuser, dat_tid};
        end
    end

    always @(negedge clk) begin
        if (rst_n && cqe_tvalid && cqe_tready) begin
            if (q_cqe.size() == 0) begin
                chk("cqe_unexpected_beat", {cqe_tdata, cqe_tstrb, cqe_tlast}, 0);
            end else begin
                chk("cqe_beat", {cqe_tdata, cqe_tstrb, cqe_tlast}, q_cqe.pop_front());
            end
        end
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_tready", in_tready, 1'b1);
        chk("rst_idle", idle, 1'b1);
        chk("rst_dat_tvalid", dat_tvalid, 1'b0);
        chk("rst_cqe_tvalid", cqe_tvalid, 1'b0);
        chk("rst_err_cnt", err_cnt, 8'd0);
        chk("rst_cnt_data", cnt_data, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // CQE frame, 4 beats, with one-clock latency probe
        exp_cqe(64'h1111_2222_3333_4409, 1'b0);
        exp_cqe(64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
        exp_cqe(64'h0123_4567_89AB_CDEF, 1'b0, 8'h0F);
        exp_cqe(64'hFEDC_BA98_7654_3210, 1'b1);
        send(64'h1111_2222_3333_4409, 8'h01, 1'b0);
        chk("lat_not_early", cqe_tvalid, 1'b0);
        send(64'hAAAA_BBBB_CCCC_DDDD, 8'h00, 1'b0);
        chk("lat_one_clk", cqe_tvalid, 1'b1);
        send(64'h0123_4567_89AB_CDEF, 8'h00, 1'b0, 8'h0F);
        send(64'hFEDC_BA98_7654_3210, 8'h02, 1'b1);
        e_cqe = 1;
        drain();
        check_state("cqe");

        // STATS frame
`ifndef CR_OB_SPLIT_STATS_DROP_EN
        exp_dat(64'hA5A5_0000_0000_0008, 8'h01);
        exp_dat(64'h5A5A_1111_2222_3333, 8'h00);
        exp_dat(64'h0000_0000_0000_00FF, 8'h02);
`endif
        send(64'hA5A5_0000_0000_0008, 8'h01, 1'b0);
        send(64'h5A5A_1111_2222_3333, 8'h00, 1'b0);
        send(64'h0000_0000_0000_00FF, 8'h02, 1'b0);
        e_stats = 1;
        drain();
        check_state("stats");

        // Data frame into a stalled dat_* port
        exp_dat(64'h0000_0000_0000_1005, 8'h01, 8'hFF, 1'b1);
        exp_dat(64'h0000_0000_0000_1001, 8'h00, 8'hFF, 1'b1);
        exp_dat(64'h0000_0000_0000_1002, 8'h00, 8'hFF, 1'b1);
        exp_dat(64'h0000_0000_0000_1003, 8'h00, 8'h3C, 1'b1);
        exp_dat(64'h0000_0000_0000_1004, 8'h02, 8'hFF, 1'b1);
        set_dat_rdy(1'b0);
        send(64'h0000_0000_0000_1005, 8'h01, 1'b0, 8'hFF, 1'b1);
        send(64'h0000_0000_0000_1001, 8'h00, 1'b0, 8'hFF, 1'b1);
        send(64'h0000_0000_0000_1002, 8'h00, 1'b0, 8'hFF, 1'b1);
        chk("stall_in_tready_low", in_tready, 1'b0);
        chk("stall_dat_tvalid", dat_tvalid, 1'b1);
        chk("stall_dat_tdata", dat_tdata, 64'h0000_0000_0000_1005);
        repeat (3) @(negedge clk);
        set_dat_rdy(1'b1);
        send(64'h0000_0000_0000_1003, 8'h00, 1'b0, 8'h3C, 1'b1);
        send(64'h0000_0000_0000_1004, 8'h02, 1'b0, 8'hFF, 1'b1);
        e_data = 1;
        drain();
        check_state("stall");

        // Data frame while dat_tready toggles 1,0,0,1,0,1
        for (int i = 0; i < 6; i++) begin
            exp_dat(64'h0000_0000_0000_2006 + 64'(i * 16),
                    (i == 0) ? 8'h01 : ((i == 5) ? 8'h02 : 8'h00));
        end
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    @(posedge clk);
                    #1 dat_tready = rdy_pat[k];
                end
            end
        join_none
        for (int i = 0; i < 6; i++) begin
            send(64'h0000_0000_0000_2006 + 64'(i * 16),
                 (i == 0) ? 8'h01 : ((i == 5) ? 8'h02 : 8'h00), 1'b0);
        end
        e_data = 2;
        drain();
        check_state("toggle");

        // Mid beat with no open frame is dropped
        send(64'h0000_0000_0000_DEAD, 8'h00, 1'b0);
        e_fr = 1;
        e_err = 1;
        drain();
        check_state("orphan_mid");

        // Data frame ending with a stray tlast
        exp_dat(64'h0000_0000_0000_0022, 8'h01);
        exp_dat(64'h0000_0000_0000_0023, 8'h02);
        send(64'h0000_0000_0000_0022, 8'h01, 1'b0);
        send(64'h0000_0000_0000_0023, 8'h02, 1'b1);
        e_tl = 1;
        e_err = 2;
        e_data = 3;
        drain();
        check_state("bad_tlast");

        // SoT inside a data frame re-types to a single-beat CQE
        exp_dat(64'h0000_0000_0000_0033, 8'h01);
        exp_cqe(64'h0000_0000_0000_7709, 1'b1);
        send(64'h0000_0000_0000_0033, 8'h01, 1'b0);
        send(64'h0000_0000_0000_7709, 8'h03, 1'b1);
        e_fr = 2;
        e_err = 3;
        e_cqe = 2;
        drain();
        check_state("resync");

        // EoT beat with tlast while idle: both errors at once
        send(64'h0000_0000_0000_0077, 8'h02, 1'b1);
        e_fr = 3;
        e_tl = 2;
        e_err = 5;
        drain();
        check_state("double_err");

        // Reset while a CQE frame is open
        send(64'h0000_0000_0000_0009, 8'h01, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mrst_cqe_tvalid", cqe_tvalid, 1'b0);
        chk("mrst_dat_tdata", dat_tdata, 64'd0);
        chk("mrst_in_tready", in_tready, 1'b1);
        chk("mrst_idle", idle, 1'b1);
        chk("mrst_err_cnt", err_cnt, 8'd0);
        chk("mrst_cnt_cqe", cnt_cqe, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        exp_dat(64'h0000_0000_0000_0044, 8'h03);
        send(64'h0000_0000_0000_0044, 8'h03, 1'b0);
        e_data = 1;
        e_cqe = 0;
        e_stats = 0;
        e_err = 0;
        drain();
        check_state("after_rst");

        // err_cnt saturation
        for (int i = 0; i < 130; i++) begin
            send(64'(i), 8'h02, 1'b1);
        end
        e_fr += 130;
        e_tl += 130;
        e_err = 255;
        drain();
        check_state("saturate");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
